// File: rtl/soc_system_gpi_pkg.sv
// Shared register-map constants and helpers for the soc_system general-purpose input PIO.
package soc_system_gpi_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RAW  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_RISE = 3'd4;
    localparam logic [2:0] ADDR_FALL = 3'd5;

    // Counter must be able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int unsigned deb_cnt_width(input int unsigned cycles);
        if (cycles < 2)
            return 1;
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/soc_system_gpi_debounce.sv
// Single-bit debounce filter: dout follows din only after din has differed
// from dout for DEBOUNCE_CYCLES consecutive cycles.
module soc_system_gpi_debounce
    import soc_system_gpi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned    CW       = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            dout <= din;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/soc_system_gpi_irq_pio.sv
// Parametrised general-purpose input PIO with edge capture and level irq.
// Define SOC_SYSTEM_GPI_DEBOUNCE_EN to insert a per-bit debounce filter after the synchroniser.
module soc_system_gpi_irq_pio
    import soc_system_gpi_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_RISE_EN   = '1,
    parameter logic [WIDTH-1:0] RESET_FALL_EN   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_ok;

    assign wr_en     = chipselect && !write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign unused_ok = &{1'b0, writedata};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++)
                sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < int'(SYNC_STAGES); s++)
                sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef SOC_SYSTEM_GPI_DEBOUNCE_EN
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_deb
        soc_system_gpi_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .din  (sync_in[i]),
            .dout (filt[i])
        );
    end
`else
    localparam int unsigned unused_deb_cycles = DEBOUNCE_CYCLES;
    assign filt = sync_in;
`endif

    assign edge_vec = (filt & ~prev & rise_en) | (~filt & prev & fall_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= RESET_RISE_EN;
            fall_en      <= RESET_FALL_EN;
            irq          <= 1'b0;
        end else begin
            prev <= filt;
            irq  <= |(edge_capture & irq_mask);
            if (wr_en && address == ADDR_MASK) irq_mask <= wdata;
            if (wr_en && address == ADDR_RISE) rise_en  <= wdata;
            if (wr_en && address == ADDR_FALL) fall_en  <= wdata;
            // New edges are OR-ed in after the clear so a coincident edge is never lost.
            if (wr_en && address == ADDR_EDGE)
                edge_capture <= (edge_capture & ~wdata) | edge_vec;
            else
                edge_capture <= edge_capture | edge_vec;
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = filt;
            ADDR_RAW:  rd_mux[WIDTH-1:0] = sync_in;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
            ADDR_RISE: rd_mux[WIDTH-1:0] = rise_en;
            ADDR_FALL: rd_mux[WIDTH-1:0] = fall_en;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_soc_system_gpi_irq_pio.sv
// Scoreboard bench for soc_system_gpi_irq_pio (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16).
module tb_soc_system_gpi_irq_pio;
    import soc_system_gpi_pkg::*;

    localparam int DEB = 16;
`ifdef SOC_SYSTEM_GPI_DEBOUNCE_EN
    localparam int EXTRA = DEB;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp_rd;
        logic        exp_irq;
        bit          chk_irq;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic rd_q  = 1'b0;

    soc_system_gpi_irq_pio #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_RISE_EN  (4'hF),
        .RESET_FALL_EN  (4'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A read issued before a posedge presents its data after that edge.
    always @(posedge clk) rd_q <= chipselect && write_n && !reset;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_q) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_read got=0x%08h", readdata);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (readdata !== e.exp_rd) begin
                        n_bad++;
                        $display("FAIL %s readdata got=0x%08h want=0x%08h", e.name, readdata, e.exp_rd);
                    end
                    if (e.chk_irq) begin
                        n_cmp++;
                        if (irq !== e.exp_irq) begin
                            n_bad++;
                            $display("FAIL %s irq got=%b want=%b", e.name, irq, e.exp_irq);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_idle();
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic rd_irq(input string nm, input logic [2:0] a, input logic [31:0] er,
                          input logic ei, input bit ci);
        exp_t t;
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        writedata  = 32'h0;
        t.name    = nm;
        t.exp_rd  = er;
        t.exp_irq = ei;
        t.chk_irq = ci;
        exp_q.push_back(t);
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] er);
        rd_irq(nm, a, er, 1'b0, 1'b0);
    endtask

    task automatic set_pins(input logic [3:0] v);
        @(negedge clk);
        bus_idle();
        in_port = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        in_port = 4'h0;
        bus_idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset defaults
        rd_irq("rst_data", ADDR_DATA, 32'h0, 1'b0, 1'b1);
        rd("rst_raw",  ADDR_RAW,  32'h0);
        rd("rst_mask", ADDR_MASK, 32'h0);
        rd("rst_edge", ADDR_EDGE, 32'h0);
        rd("rst_rise", ADDR_RISE, 32'hF);
        rd("rst_fall", ADDR_FALL, 32'h0);
        rd("rst_a7",   3'd7,      32'h0);
        wr(3'd6, 32'hFFFF_FFFF);
        rd("a6_ignored", 3'd6, 32'h0);

        // Rising edges with exact capture and irq latency
        wr(ADDR_MASK, 32'hFFFF_FFF5);
        rd("mask_wr", ADDR_MASK, 32'h5);
        set_pins(4'h5);
        idle(1 + EXTRA);
        rd_irq("rise_early", ADDR_EDGE, 32'h0, 1'b0, 1'b1);
        rd_irq("rise_cap",   ADDR_EDGE, 32'h5, 1'b1, 1'b1);
        rd("rise_data", ADDR_DATA, 32'h5);
        rd("rise_raw",  ADDR_RAW,  32'h5);
        wr(ADDR_EDGE, 32'h5);
        rd_irq("rise_clear", ADDR_EDGE, 32'h0, 1'b0, 1'b1);

        // Falling-edge selection
        wr(ADDR_RISE, 32'h0);
        wr(ADDR_FALL, 32'h2);
        set_pins(4'h7);
        idle(4 + EXTRA);
        rd("fall_rise_ignored", ADDR_EDGE, 32'h0);
        set_pins(4'h5);
        idle(4 + EXTRA);
        rd_irq("fall_cap", ADDR_EDGE, 32'h2, 1'b0, 1'b1);
        set_pins(4'h7);
        idle(4 + EXTRA);
        rd("fall_no_rise", ADDR_EDGE, 32'h2);
        wr(ADDR_EDGE, 32'h2);
        rd("fall_clear", ADDR_EDGE, 32'h0);

        // Clear coinciding with a new edge on bit 0
        wr(ADDR_FALL, 32'h0);
        wr(ADDR_RISE, 32'hF);
        set_pins(4'h6);
        idle(4 + EXTRA);
        wr(ADDR_EDGE, 32'hF);
        rd("coll_pre", ADDR_EDGE, 32'h0);
        set_pins(4'h7);
        idle(1 + EXTRA);
        wr(ADDR_EDGE, 32'h1);
        rd("coll_set_wins", ADDR_EDGE, 32'h1);
        wr(ADDR_EDGE, 32'h0);
        rd("write0_noeffect", ADDR_EDGE, 32'h1);
        wr(ADDR_EDGE, 32'h1);
        rd("coll_clear", ADDR_EDGE, 32'h0);

        // Mask gating
        wr(ADDR_MASK, 32'h7);
        set_pins(4'hF);
        idle(4 + EXTRA);
        rd_irq("mask_gated", ADDR_EDGE, 32'h8, 1'b0, 1'b1);
        wr(ADDR_MASK, 32'hF);
        rd_irq("mask_open", ADDR_MASK, 32'hF, 1'b1, 1'b1);
        rd("mask_data", ADDR_DATA, 32'hF);

`ifdef SOC_SYSTEM_GPI_DEBOUNCE_EN
        wr(ADDR_MASK, 32'h0);
        set_pins(4'h0);
        idle(30);
        wr(ADDR_EDGE, 32'hF);
        rd("deb_pre_edge", ADDR_EDGE, 32'h0);
        rd("deb_pre_data", ADDR_DATA, 32'h0);

        // 10-cycle glitch must be rejected
        set_pins(4'h1);
        idle(9);
        set_pins(4'h0);
        idle(30);
        rd("deb_pulse_data", ADDR_DATA, 32'h0);
        rd("deb_pulse_edge", ADDR_EDGE, 32'h0);

        // Steady level accepted exactly SYNC_STAGES+16 cycles after the pin change
        set_pins(4'h1);
        idle(16);
        rd("deb_steady_early", ADDR_DATA, 32'h0);
        rd("deb_steady",       ADDR_DATA, 32'h1);
        idle(5);
        rd("deb_steady_edge", ADDR_EDGE, 32'h1);

        // Reset in the middle of a count
        set_pins(4'h0);
        idle(8);
        do_reset();
        rd("deb_rst_data", ADDR_DATA, 32'h0);
        rd("deb_rst_edge", ADDR_EDGE, 32'h0);
        rd("deb_rst_rise", ADDR_RISE, 32'hF);
        set_pins(4'h1);
        idle(16);
        rd("deb_after_rst_early", ADDR_DATA, 32'h0);
        rd("deb_after_rst",       ADDR_DATA, 32'h1);
`endif

        idle(3);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp += exp_q.size();
            n_bad += exp_q.size();
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
